score_sequencer: RTL
====================

// Module: score_sequencer
// PURPOSE
//  Plays a melody from the score ROM by consuming beat codes and turning them back into timed note intervals.
//  Fetches one 12-bit entry per note: pitch code [11:4] and beat code [3:0].
//  Holds each pitch for the decoded duration, then mutes for an articulation gap, then advances.
//  Sits between the score ROM and the buzzer tone generator, which consumes pitch_code and tone_en.
// PARAMETERS
//  WHOLE_CNT  50_000_000  cycles in a whole note; other beats are WHOLE_CNT >> (beat-1)
//  GAP_CNT    500_000     muted cycles at the tail of every note; must be < WHOLE_CNT/16
//  ADDR_W     8           score ROM address width
// PORTS
//  clk          in   1       system clock; single clock domain
//  rst_n        in   1       asynchronous, active-low reset
//  start        in   1       1-cycle pulse; starts play from address 0 (ignored unless IDLE)
//  stop         in   1       level/pulse; aborts play, highest priority after reset
//  loop_en      in   1       1 = restart at address 0 after end marker
//  rom_addr     out  ADDR_W  score ROM address, registered
//  rom_data     in   12      ROM read data, valid 1 cycle after rom_addr (sync ROM)
//  pitch_code   out  8       current pitch; 0 = rest
//  tone_en      out  1       1 = drive buzzer (PLAY state and pitch_code != 0)
//  note_strobe  out  1       1-cycle pulse when a valid note is loaded
//  busy         out  1       1 in every state except IDLE
//  done         out  1       1-cycle pulse when score ends with loop_en = 0
// BEHAVIOUR
//  Reset: state IDLE; rom_addr=0, pitch_code=0, tone_en=0, note_strobe=0, busy=0, done=0, counter=0.
//  Beat codes: 1 whole, 2 half, 3 quarter, 4 eighth, 5 sixteenth; 0 and 6..15 = end-of-score marker.
//  FSM states: IDLE, FETCH, LOAD, PLAY, GAP, END.
//  - IDLE:  start=1 -> rom_addr<=0, FETCH.
//  - FETCH: wait one cycle for ROM data -> LOAD.
//  - LOAD:  latch rom_data.
//           Valid beat: pitch_code<=data[11:4]; counter<=dur-GAP_CNT-1; note_strobe=1; -> PLAY.
//           Invalid beat: -> END.
//  - PLAY:  tone_en = (pitch_code != 0); count down; at 0, counter<=GAP_CNT-1 -> GAP.
//  - GAP:   tone_en=0; count down; at 0, rom_addr<=rom_addr+1 -> FETCH.
//  - END:   loop_en=1: rom_addr<=0 -> FETCH.
//           loop_en=0: done=1 for one cycle, pitch_code<=0 -> IDLE.
//  Timing: total note period = dur + 2 cycles (FETCH + LOAD + PLAY(dur-GAP) + GAP(GAP_CNT)).
//  Counter: 28 bits; dur computed as WHOLE_CNT >> (beat-1), unsigned, no rounding.
//  rom_addr wrap: max address with a valid note wraps to 0 and play continues; no done pulse.
//  stop=1 in any state -> IDLE next cycle.
//    tone_en=0 and pitch_code=0 on that cycle edge; rom_addr holds; done not pulsed.
//  start and stop asserted together: stop wins.
//  start while busy: ignored.
//  Reset mid-note: immediate return to reset values, no glitch on tone_en (registered output).
//  All outputs registered; note_strobe and done never high together.
// STRUCTURE
//  Shared package beat_pkg holds:
//    - beat code localparams (BEAT_WHOLE..BEAT_16TH)
//    - 12-bit entry field positions
//    - state enum encoding
//    - function beat_to_cnt(beat, whole) returning 28-bit duration (0 for invalid codes)
//  One sub-module, beat_down_counter:
//    loadable 28-bit down counter with load/en/zero flag, used for both PLAY and GAP.
// TESTING (WHOLE_CNT=1600, GAP_CNT=10 for all tests)
//  1 ROM {0x21_3, 0x00_0}, start.
//    -> tone_en high 390 cycles, pitch 0x21, low 10, then done pulse; busy drops.
//  2 ROM beats 1,2,3,4,5 then end.
//    -> PLAY lengths 1590/790/390/190/90; note periods 1602/802/402/202/102; 5 note_strobes.
//  3 Rest entry {0x00_4}.
//    -> tone_en stays 0 for full 202-cycle period; note_strobe still pulses.
//  4 loop_en=1 with 2-note score.
//    -> after end marker rom_addr returns to 0; no done; third strobe at same pitch as first.
//  5 stop mid-PLAY at cycle 100.
//    -> next cycle tone_en=0, busy=0, pitch_code=0; start then restarts at rom_addr 0.
//  6 rst_n low mid-GAP; start and stop together in IDLE.
//    -> all outputs at reset values immediately; simultaneous start+stop stays IDLE.

Source files
------------

// File: rtl/beat_pkg.sv
// rtl/beat_pkg.sv - shared beat codes, score entry fields, sequencer states and duration decode
package beat_pkg;

    localparam logic [3:0] BEAT_WHOLE   = 4'd1;
    localparam logic [3:0] BEAT_HALF    = 4'd2;
    localparam logic [3:0] BEAT_QUARTER = 4'd3;
    localparam logic [3:0] BEAT_8TH     = 4'd4;
    localparam logic [3:0] BEAT_16TH    = 4'd5;

    localparam int PITCH_MSB = 11;
    localparam int PITCH_LSB = 4;
    localparam int BEAT_MSB  = 3;
    localparam int BEAT_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_END
    } state_t;

    // A zero duration doubles as the end-of-score marker.
    function automatic logic [27:0] beat_to_cnt(input logic [3:0] beat, input logic [27:0] whole);
        logic [27:0] r;
        r = '0;
        case (beat)
            BEAT_WHOLE:   r = whole;
            BEAT_HALF:    r = whole >> 1;
            BEAT_QUARTER: r = whole >> 2;
            BEAT_8TH:     r = whole >> 3;
            BEAT_16TH:    r = whole >> 4;
            default:      r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/beat_down_counter.sv
// rtl/beat_down_counter.sv - loadable down counter with zero flag, shared by note and gap timing
module beat_down_counter #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - walks the score ROM and turns beat codes into timed pitch/mute intervals
module score_sequencer
    import beat_pkg::*;
#(
    parameter int unsigned WHOLE_CNT = 50_000_000,
    parameter int unsigned GAP_CNT   = 500_000,
    parameter int          ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_data,
    output logic [7:0]        pitch_code,
    output logic              tone_en,
    output logic              note_strobe,
    output logic              busy,
    output logic              done
);

    localparam logic [27:0] WHOLE_C = 28'(WHOLE_CNT);
    localparam logic [27:0] GAP_C   = 28'(GAP_CNT);

    state_t      state;
    logic [27:0] dur;
    logic        beat_ok;
    logic [7:0]  data_pitch;
    logic        cnt_load;
    logic        cnt_en;
    logic [27:0] cnt_val;
    logic        cnt_zero;

    assign dur        = beat_to_cnt(rom_data[BEAT_MSB:BEAT_LSB], WHOLE_C);
    assign beat_ok    = (dur != '0);
    assign data_pitch = rom_data[PITCH_MSB:PITCH_LSB];

    // The counter runs PLAY down to zero, is reloaded for the gap on that same edge, then runs GAP.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = GAP_C - 28'd1;
        if (!stop) begin
            if (state == ST_LOAD) begin
                cnt_load = beat_ok;
                cnt_val  = dur - GAP_C - 28'd1;
            end else if (state == ST_PLAY) begin
                cnt_load = cnt_zero;
                cnt_en   = 1'b1;
            end else if (state == ST_GAP) begin
                cnt_en   = 1'b1;
            end
        end
    end

    beat_down_counter #(.W(28)) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rom_addr    <= '0;
            pitch_code  <= '0;
            tone_en     <= 1'b0;
            note_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state      <= ST_IDLE;
                pitch_code <= '0;
                tone_en    <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            rom_addr <= '0;
                            busy     <= 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                    ST_FETCH: state <= ST_LOAD;
                    ST_LOAD: begin
                        if (beat_ok) begin
                            pitch_code  <= data_pitch;
                            tone_en     <= (data_pitch != '0);
                            note_strobe <= 1'b1;
                            state       <= ST_PLAY;
                        end else begin
                            state <= ST_END;
                        end
                    end
                    ST_PLAY: begin
                        if (cnt_zero) begin
                            tone_en <= 1'b0;
                            state   <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_zero) begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                    ST_END: begin
                        if (loop_en) begin
                            rom_addr <= '0;
                            state    <= ST_FETCH;
                        end else begin
                            done       <= 1'b1;
                            pitch_code <= '0;
                            busy       <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
